// File: rtl/fifo_pkg.sv
// Shared widths and types for the streaming FIFO and its RAM.
package fifo_pkg;

    localparam int unsigned FIFO_DW    = 16;
    localparam int unsigned FIFO_AW    = 5;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   cnt_t;
    typedef logic [FIFO_DW-1:0] word_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(FIFO_DEPTH);

endpackage

// File: rtl/stream_fifo_32x16_if.sv
// Producer/consumer handshake bundle plus occupancy status of the FIFO.
interface stream_fifo_32x16_if
    import fifo_pkg::*;
();

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    cnt_t  count;
    logic  full;
    logic  empty;

    // Environment side: drives producer data and consumer ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, full, empty
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, full, empty
    );

endinterface

// File: rtl/dpram_32x16.sv
// 32x16 dual-port RAM: synchronous write, one-cycle registered read that
// holds its output while rd is low. Reset clears only the output register.
module dpram_32x16
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr,
    input  ptr_t  waddr,
    input  word_t d_in,
    input  logic  rd,
    input  ptr_t  raddr,
    output word_t d_out
);

    word_t mem [FIFO_DEPTH];

    // Array write; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[waddr] <= d_in;
        end
    end

    // Registered read port, holds value when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= '0;
        end else if (rd) begin
            d_out <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_fifo_32x16.sv
// First-word-fall-through FIFO around dpram_32x16. The head word lives in the
// RAM's read register; ram_cnt tracks words still in the array behind it.
module stream_fifo_32x16
    import fifo_pkg::*;
(
    input logic                clk,
    input logic                rst,
    stream_fifo_32x16_if.slave bus
);

    ptr_t  wptr_q, wptr_d;
    ptr_t  rptr_q, rptr_d;
    cnt_t  ram_cnt_q, ram_cnt_d;
    logic  out_valid_q, out_valid_d;
    logic  push, fetch;
    cnt_t  count;
    word_t rd_data;

    // Status is derived from registers only, so in_ready never sees out_ready.
    assign count        = ram_cnt_q + cnt_t'(out_valid_q);
    assign bus.count    = count;
    assign bus.full     = (count == DEPTH_CNT);
    assign bus.empty    = (count == '0);
    assign bus.in_ready = (count < DEPTH_CNT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = rd_data;

    assign push  = bus.in_valid && bus.in_ready;
    // A word written this edge is not yet counted, so same-address
    // read/write can never coincide.
    assign fetch = (ram_cnt_q != '0) && (!out_valid_q || bus.out_ready);

    // Next-state for pointers, RAM occupancy and head-valid flag.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_valid_d = out_valid_q;
        ram_cnt_d   = ram_cnt_q + cnt_t'(push) - cnt_t'(fetch);
        if (push) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (fetch) begin
            rptr_d      = rptr_q + ptr_t'(1);
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    dpram_32x16 u_ram (
        .clk   (clk),
        .rst   (rst),
        .wr    (push),
        .waddr (wptr_q),
        .d_in  (bus.in_data),
        .rd    (fetch),
        .raddr (rptr_q),
        .d_out (rd_data)
    );

endmodule

// File: doc/stream_fifo_32x16.md
# stream_fifo_32x16

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides, built around a 32x16 dual-port RAM. It owns the write/read pointers, occupancy tracking and RAM read scheduling, and turns the RAM's raw `wr`/`waddr`/`rd`/`raddr` port into a streaming buffer. It sits between a 16-bit producer and a 16-bit consumer, and absorbs up to 32 words of rate mismatch.

## Interface
- `DW`, 16, data width
- `AW`, 5, address width; `DEPTH = 2**AW` = 32 words
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  FIFO accepts a word this cycle
- `in_data`  in  DW  word to store
- `out_valid`  out  1  `out_data` holds the head word
- `out_ready`  in  1  consumer takes the head word this cycle
- `out_data`  out  DW  head word, taken directly from the RAM's registered read output
- `count`  out  AW+1  words held, 0..32 (RAM plus head)
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`

## Operation
- Push: `in_valid && in_ready` at an edge.
  - RAM `wr=1`, `waddr=wptr`, `d_in=in_data`.
  - `wptr` increments mod 32; `ram_cnt` increments.
- `in_ready = (count < DEPTH)`, combinational on registered state only. There is no pass-through when full: a simultaneous pop does not free a slot in the same cycle.
- Fetch: issued when `ram_cnt > 0 && (!out_valid || out_ready)`.
  - RAM `rd=1`, `raddr=rptr`.
  - At the edge: `rptr` increments mod 32, `ram_cnt` decrements, `out_valid` is set to 1.
- Pop without fetch: when `out_valid && out_ready` and no fetch is issued, `out_valid` clears.
- The RAM holds `d_out` while `rd=0`, so the head word stays stable until it is popped.
- `count = ram_cnt + out_valid`.
- Simultaneous push and fetch in one cycle: both happen. `ram_cnt` is net unchanged.
- Same-address read/write hazard cannot occur. A word becomes fetchable only after its write edge, so `rptr == wptr` with `ram_cnt == 0` blocks the fetch.
- Pointers wrap 31 -> 0 with no special casing. Full/empty are decided by the counts, never by pointer compare.

## Timing
- Reset (async, immediate), required output values:
  - `wptr = 0`, `rptr = 0`, `ram_cnt = 0`
  - `out_valid = 0`, `count = 0`, `empty = 1`, `full = 0`, `in_ready = 1`
  - `out_data = 0` (RAM output register cleared)
  - RAM array contents are undefined after reset and are never read before being rewritten.
- Reset mid-stream discards all held words. The first push after `rst` falls behaves as from empty.
- Write-to-read latency: push at edge E0 -> fetch during the next cycle -> `out_valid=1` after E1. First word appears 2 edges after it is offered.
- Steady-state throughput: one push and one pop per cycle, sustained, with `count` constant.
- With `out_ready` held high, the head is replaced every cycle while `ram_cnt > 0`. When `ram_cnt == 0`, `out_valid` drops after the pop edge.
- `out_valid` never deasserts without a pop. `out_data` is stable while `out_valid && !out_ready`.
- `full`, `empty`, `count` and `in_ready` are derived from registers only, so no combinational path runs from `out_ready` to `in_ready`.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_DW = 16`, `FIFO_AW = 5`
  - `ptr_t` (AW bits)
  - `cnt_t` (AW+1 bits)
- One sub-module, `dpram_32x16`: the existing dual-port RAM (ports `clk`, `rst`, `wr`, `waddr`, `d_in`, `rd`, `raddr`, `d_out`). It has a synchronous write, a one-cycle registered read, `d_out` holds when `rd=0`, and `rst` clears `d_out`.
- Control logic (pointers, `ram_cnt`, `out_valid`) lives in the top.

## Test plan
- Reset, then a single push of 16'haabb, `out_ready=0` -> `out_valid` rises 2 edges later with `out_data=aabb`, `count=1`; it holds until `out_ready=1`, then `empty=1`.
- Push 32 words 16'h0000..16'h001f, no pops -> `full=1`, `in_ready=0`, `count=32`. A 33rd word is not accepted. Drain -> data in order 0000..001f, then `empty=1`.
- Wrap: push 20, pop 20, push 20 -> pointers cross 31->0. Output is the exact second sequence with no gaps while `out_ready=1`.
- Continuous push and pop with `out_ready=1` every cycle -> one word per cycle out, in order, `count` steady at 1 or 2.
- Full, with `in_valid=1` and `out_ready=1` in the same cycle -> pop occurs, push refused that cycle, accepted the next cycle; `count` goes 32->31->32.
- Assert `rst` mid-burst with `count=10` -> outputs return immediately to reset values. A subsequent push of 16'habcd is the next word out.
